// File: rtl/sat_unit_arbiter_if.sv
// sat_unit_arbiter_if: request fan-in and tagged response bus for the shared saturation unit.
// Revision: 1.0
`default_nettype none

interface sat_unit_arbiter_if #(
  parameter int NREQ = 4,
  parameter int INW  = 16,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*INW-1:0] req_data;
  logic [NREQ*2-1:0]   req_mode;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [INW-1:0]      rsp_data;
  logic                rsp_sat;

  modport master (
    output req_valid, req_data, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat
  );

  modport slave (
    input  req_valid, req_data, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat
  );
endinterface

`default_nettype wire

// File: rtl/sat_unit_arbiter.sv
// sat_unit_arbiter: round-robin arbiter in front of a 2-stage saturate/round pipe.
// Revision: 1.0
`default_nettype none

module sat_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int INW  = 16,
  parameter int OUTW = 8,
  parameter int IDW  = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  sat_unit_arbiter_if.slave bus,
  input  wire logic         sat_clear,
  output logic [15:0]       sat_count
);

  typedef enum logic [1:0] {
    MODE_SRANGE = 2'd0,
    MODE_SPOS   = 2'd1,
    MODE_UPOS   = 2'd2,
    MODE_RTZEM1 = 2'd3
  } mode_e;

  localparam logic [INW-1:0] SMAX    = INW'((1 << (OUTW - 1)) - 1);
  localparam logic [INW-1:0] SMIN    = ~SMAX;
  localparam logic [INW-1:0] UMAX    = INW'((1 << OUTW) - 1);
  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           s1_valid_q;
  logic [INW-1:0] s1_data_q;
  mode_e          s1_mode_q;
  logic [IDW-1:0] s1_id_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [INW-1:0] rsp_data_q;
  logic           rsp_sat_q;
  logic [15:0]    sat_count_q, sat_count_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           s2_load;
  logic           s1_can_load;
  logic           xfer;
  logic [INW-1:0] res_data;
  logic           res_sat;

  // Search starts one past the last grantee so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!grant_found && bus.req_valid[(int'(ptr_q) + i) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign s2_load     = s1_valid_q && (!rsp_valid_q || bus.rsp_ready);
  assign s1_can_load = !s1_valid_q || s2_load;
  assign xfer        = grant_found && s1_can_load && !rst;
  assign ptr_d       = xfer ? grant_idx : ptr_q;

  assign bus.req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    res_data = s1_data_q;
    res_sat  = 1'b0;
    case (s1_mode_q)
      MODE_SRANGE: begin
        if ($signed(s1_data_q) > $signed(SMAX)) begin
          res_data = SMAX;
          res_sat  = 1'b1;
        end else if ($signed(s1_data_q) < $signed(SMIN)) begin
          res_data = SMIN;
          res_sat  = 1'b1;
        end
      end
      MODE_SPOS: begin
        if (s1_data_q[INW-1]) begin
          res_data = '0;
          res_sat  = 1'b1;
        end else if (s1_data_q > UMAX) begin
          res_data = UMAX;
          res_sat  = 1'b1;
        end
      end
      MODE_UPOS: begin
        if (s1_data_q > UMAX) begin
          res_data = UMAX;
          res_sat  = 1'b1;
        end
      end
      MODE_RTZEM1: begin
        // -1 is already the nearest-to-zero negative value; leave it alone.
        if (s1_data_q[INW-1] && (s1_data_q != '1)) begin
          res_data = s1_data_q + INW'(1);
        end
      end
      default: begin
        res_data = s1_data_q;
        res_sat  = 1'b0;
      end
    endcase
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (rsp_valid_q && bus.rsp_ready && rsp_sat_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= PTR_RST;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= MODE_SRANGE;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      sat_count_q <= sat_count_d;

      if (xfer) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= bus.req_data[int'(grant_idx)*INW +: INW];
        s1_mode_q  <= mode_e'(bus.req_mode[int'(grant_idx)*2 +: 2]);
        s1_id_q    <= grant_idx;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_load) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= s1_id_q;
        rsp_data_q  <= res_data;
        rsp_sat_q   <= res_sat;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_sat   = rsp_sat_q;
  assign sat_count     = sat_count_q;

endmodule

`default_nettype wire
